// File: rtl/fp8_array_sequencer.sv
// Job sequencer for an N x N FP8 systolic array: clears accumulators, feeds K skewed
// operand steps, waits for the array to drain, then streams accumulator rows out.
module fp8_array_sequencer #(
   parameter int N      = 4,
   parameter int K_MAX  = 16,
   parameter int ADDR_W = 4,
   parameter int ROW_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   k_len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pe_clear,
   output logic              buf_rd_en,
   output logic [ADDR_W-1:0] buf_rd_addr,
   output logic [N-1:0]      feed_valid,
   output logic [ROW_W-1:0]  rd_row,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int                DRAIN_W    = $clog2(2 * N);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * N - 1);
   localparam logic [ADDR_W:0]   K_MAX_V    = (ADDR_W + 1)'(K_MAX);
   localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(N - 1);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     k_len_q, k_len_d;
   logic [ADDR_W:0]     k_cnt_q, k_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic [ROW_W-1:0]    rd_row_q, rd_row_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pe_clear_q, pe_clear_d;
   logic                buf_rd_en_q, buf_rd_en_d;
   logic [ADDR_W-1:0]   buf_rd_addr_q, buf_rd_addr_d;
   logic [N-1:0]        feed_valid_q, feed_valid_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic                abort_clr_s;

   // Next-state and counter update; outputs are decoded from the next state so they register cleanly.
   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      k_cnt_d     = k_cnt_q;
      drain_cnt_d = drain_cnt_q;
      rd_row_d    = rd_row_q;
      abort_clr_s = 1'b0;

      if ((state_q != S_IDLE) && abort) begin
         state_d     = S_IDLE;
         k_cnt_d     = '0;
         drain_cnt_d = '0;
         rd_row_d    = '0;
         abort_clr_s = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort && (k_len != '0) && (k_len <= K_MAX_V)) begin
                  k_len_d = k_len;
                  state_d = S_CLEAR;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CLEAR: begin
               k_cnt_d = '0;
               state_d = S_FEED;
            end
            S_FEED: begin
               if (k_cnt_q == (k_len_q - (ADDR_W + 1)'(1))) begin
                  k_cnt_d     = '0;
                  drain_cnt_d = '0;
                  state_d     = S_DRAIN;
               end else begin
                  k_cnt_d = k_cnt_q + (ADDR_W + 1)'(1);
               end
            end
            S_DRAIN: begin
               if (drain_cnt_q == DRAIN_LAST) begin
                  drain_cnt_d = '0;
                  rd_row_d    = '0;
                  state_d     = S_READ;
               end else begin
                  drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
               end
            end
            S_READ: begin
               if (out_ready && (rd_row_q == ROW_LAST)) begin
                  rd_row_d = '0;
                  state_d  = S_DONE;
               end else if (out_ready) begin
                  rd_row_d = rd_row_q + ROW_W'(1);
               end else begin
                  rd_row_d = rd_row_q;
               end
            end
            S_DONE: begin
               rd_row_d = '0;
               state_d  = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d        = (state_d != S_IDLE);
      done_d        = (state_d == S_DONE);
      pe_clear_d    = (state_d == S_CLEAR) || abort_clr_s;
      buf_rd_en_d   = (state_d == S_FEED);
      buf_rd_addr_d = buf_rd_en_d ? k_cnt_d[ADDR_W-1:0] : '0;
      // Lane 0 follows the read strobe by the buffer latency; lane i adds i cycles of skew.
      feed_valid_d  = abort_clr_s ? '0 : {feed_valid_q[N-2:0], buf_rd_en_q};
      out_valid_d   = (state_d == S_READ);
      out_last_d    = out_valid_d && (rd_row_d == ROW_LAST);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         k_len_q       <= '0;
         k_cnt_q       <= '0;
         drain_cnt_q   <= '0;
         rd_row_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pe_clear_q    <= 1'b0;
         buf_rd_en_q   <= 1'b0;
         buf_rd_addr_q <= '0;
         feed_valid_q  <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_len_q       <= k_len_d;
         k_cnt_q       <= k_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         rd_row_q      <= rd_row_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pe_clear_q    <= pe_clear_d;
         buf_rd_en_q   <= buf_rd_en_d;
         buf_rd_addr_q <= buf_rd_addr_d;
         feed_valid_q  <= feed_valid_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pe_clear    = pe_clear_q;
   assign buf_rd_en   = buf_rd_en_q;
   assign buf_rd_addr = buf_rd_addr_q;
   assign feed_valid  = feed_valid_q;
   assign rd_row      = rd_row_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;

endmodule

// File: tb/tb_fp8_array_sequencer.sv
// Directed bench for fp8_array_sequencer (N=4, K_MAX=16): waveform, backpressure,
// ignored starts, max K with back-to-back job, abort in DRAIN, and async reset mid-FEED.
module tb_fp8_array_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] k_len;
   logic       abort;
   logic       busy;
   logic       done;
   logic       pe_clear;
   logic       buf_rd_en;
   logic [3:0] buf_rd_addr;
   logic [3:0] feed_valid;
   logic [1:0] rd_row;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   int total = 0;
   int bad   = 0;

   fp8_array_sequencer #(.N(4), .K_MAX(16), .ADDR_W(4), .ROW_W(2)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
      .busy(busy), .done(done), .pe_clear(pe_clear), .buf_rd_en(buf_rd_en),
      .buf_rd_addr(buf_rd_addr), .feed_valid(feed_valid), .rd_row(rd_row),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [4:0] k);
      start = 1'b1;
      k_len = k;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   function automatic logic [15:0] pack_obs();
      return {busy, done, pe_clear, buf_rd_en, buf_rd_addr, feed_valid, rd_row, out_valid, out_last};
   endfunction

   initial begin
      logic [15:0] exp_v;
      logic [3:0]  e_fv;
      logic [3:0]  e_addr;
      logic [1:0]  e_row;
      int          xfers;
      int          n;
      int          seen_done;
      int          seen_valid;

      rst = 1'b1; start = 1'b0; k_len = 5'd0; abort = 1'b0; out_ready = 1'b1;
      #12;
      check("reset_state", {16'd0, pack_obs()}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Reference waveform: k_len=3, start in cycle 0.
      start = 1'b1; k_len = 5'd3;
      for (int c = 1; c <= 18; c++) begin
         tick();
         start = 1'b0;
         for (int i = 0; i < 4; i++) e_fv[i] = (c >= 3 + i) && (c <= 5 + i);
         e_addr = ((c >= 2) && (c <= 4)) ? 4'(c - 2) : 4'd0;
         e_row  = ((c >= 13) && (c <= 16)) ? 2'(c - 13) : 2'd0;
         exp_v = {((c >= 1) && (c <= 17)), (c == 17), (c == 1), ((c >= 2) && (c <= 4)),
                  e_addr, e_fv, e_row, ((c >= 13) && (c <= 16)), (c == 16)};
         check($sformatf("wave_c%0d", c), {16'd0, pack_obs()}, {16'd0, exp_v});
      end

      // Backpressure at rd_row=1 for 5 cycles.
      start_job(5'd2);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check("bp_reach_read", {31'd0, out_valid}, 32'd1);
      xfers = 1;
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_row_hold%0d", i), {30'd0, rd_row}, 32'd1);
         check($sformatf("bp_valid_hold%0d", i), {31'd0, out_valid}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      n = 0;
      while (!done && n < 20) begin
         if (out_valid && out_ready) xfers++;
         tick();
         n++;
      end
      check("bp_done", {31'd0, done}, 32'd1);
      check("bp_xfers", 32'(xfers), 32'd4);
      tick();

      // Illegal k_len and abort-in-IDLE starts are ignored.
      start = 1'b1; k_len = 5'd0;
      tick();
      start = 1'b0;
      tick();
      check("ign_klen0", {31'd0, busy}, 32'd0);
      start = 1'b1; k_len = 5'd17;
      tick();
      start = 1'b0;
      tick();
      check("ign_klen17", {31'd0, busy}, 32'd0);
      start = 1'b1; k_len = 5'd3; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      tick();
      check("ign_abort_start", {31'd0, busy}, 32'd0);

      // start during FEED does not restart the job.
      start_job(5'd4);
      tick();
      check("feed_start_a0", {27'd0, buf_rd_en, buf_rd_addr}, {27'd0, 1'b1, 4'd0});
      start = 1'b1; k_len = 5'd2;
      tick();
      start = 1'b0;
      check("feed_start_a1", {27'd0, buf_rd_en, buf_rd_addr}, {27'd0, 1'b1, 4'd1});
      tick();
      tick();
      check("feed_start_a3", {27'd0, buf_rd_en, buf_rd_addr}, {27'd0, 1'b1, 4'd3});
      tick();
      check("feed_start_drain", {30'd0, busy, buf_rd_en}, {30'd0, 1'b1, 1'b0});
      wait_done("feed_start_done");
      tick();
      tick();
      check("feed_start_no_job2", {31'd0, busy}, 32'd0);

      // k_len=16: full address range, then back-to-back k_len=1.
      start_job(5'd16);
      check("k16_clear", {31'd0, pe_clear}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check($sformatf("k16_addr%0d", i), {27'd0, buf_rd_en, buf_rd_addr}, {27'd0, 1'b1, 4'(i)});
      end
      tick();
      check("k16_end", {31'd0, buf_rd_en}, 32'd0);
      wait_done("k16_done");
      tick();
      check("b2b_idle", {31'd0, busy}, 32'd0);
      start_job(5'd1);
      check("b2b_clear", {30'd0, busy, pe_clear}, {30'd0, 1'b1, 1'b1});
      tick();
      check("b2b_addr0", {27'd0, buf_rd_en, buf_rd_addr}, {27'd0, 1'b1, 4'd0});
      tick();
      check("b2b_feed_end", {31'd0, buf_rd_en}, 32'd0);
      wait_done("b2b_done");
      tick();

      // Abort in DRAIN.
      start_job(5'd2);
      tick(); tick(); tick(); tick();
      check("ab_in_drain", {30'd0, busy, buf_rd_en}, {30'd0, 1'b1, 1'b0});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_next", {28'd0, busy, pe_clear, done, out_valid}, {28'd0, 4'b0100});
      check("ab_fv_flush", {28'd0, feed_valid}, 32'd0);
      seen_done = 0; seen_valid = 0;
      tick();
      check("ab_clear_once", {31'd0, pe_clear}, 32'd0);
      for (int i = 0; i < 30; i++) begin
         if (done) seen_done++;
         if (out_valid) seen_valid++;
         tick();
      end
      check("ab_no_done", 32'(seen_done), 32'd0);
      check("ab_no_valid", 32'(seen_valid), 32'd0);

      // Asynchronous reset mid-FEED.
      start_job(5'd8);
      tick(); tick(); tick(); tick();
      check("rst_pre_feed", {31'd0, buf_rd_en}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async", {25'd0, busy, buf_rd_en, feed_valid, done}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      check("rst_idle", {16'd0, pack_obs()}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
